reg_dump_streamer: RTL and testbench

Debug-side reader for the processor register file. On a start pulse it walks architectural registers x0..x31 through the register file's debug read port. It emits each value as one beat on a valid/ready stream toward the debug/host link. It never writes the register file and needs no pipeline stall, so a dump is not an atomic snapshot.

---
 rtl/reg_dump_streamer.sv | 189 ++++++++++++++++++
 tb/tb_reg_dump_streamer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer
//
// Debug-side reader for the processor register file. A start pulse walks
// x0..x31 through the register file's debug read port. Each value goes out
// as one beat on a valid/ready stream. The register file is never written
// and the core is not stalled, so a dump is not an atomic snapshot.
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   When it is defined, every accepted data beat is XOR-folded into an
//   accumulator. A 33rd beat (out_sum=1, out_last=1, out_index=0) then
//   carries that accumulator.
//   When it is undefined, the dump is 32 beats, out_last marks x31 and
//   out_sum is tied to 0.
//
// Ports
//   clk            system clock, rising-edge
//   rst            synchronous active-high reset
//   start          dump request, sampled only in IDLE
//   debug_reg      register index to the register file debug port
//   debug_reg_out  debug read data, combinational from debug_reg
//   out_data       beat payload (registered)
//   out_index      register number of the current beat
//   out_sum        current beat is the checksum beat
//   out_last       final beat of the dump
//   out_valid      beat available
//   out_ready      consumer accepts beat
//   busy           high in any state other than IDLE
//   done           one-cycle pulse after the final handshake
//
// state | meaning
// IDLE  | waiting for start, index and accumulator cleared
// FETCH | one cycle: debug read of x[idx] captured into the beat registers
// SEND  | beat presented, held until the handshake
// SUM   | checksum beat presented (DUMP_CHECKSUM_EN only)

module reg_dump_streamer #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [4:0]           debug_reg,
    input  logic [WORD_SIZE-1:0] debug_reg_out,
    output logic [WORD_SIZE-1:0] out_data,
    output logic [4:0]           out_index,
    output logic                 out_sum,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2, SUM = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2} state_t;
`endif

    state_t     state;
    state_t     state_next;
    logic [4:0] idx;
    logic       handshake;
    logic       idx_last;

`ifdef DUMP_CHECKSUM_EN
    logic [WORD_SIZE-1:0] acc;
    logic                 sum_q;
    assign out_sum = sum_q;
`else
    assign out_sum = 1'b0;
`endif

    assign debug_reg = idx;
    assign handshake = out_valid & out_ready;
    assign idx_last  = (idx == 5'd31);

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: state_next = SEND;
            SEND: begin
                if (handshake) begin
                    if (!idx_last)
                        state_next = FETCH;
                    else
`ifdef DUMP_CHECKSUM_EN
                        state_next = SUM;
`else
                        state_next = IDLE;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            SUM:   if (handshake) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        busy      = (state != IDLE);
`ifdef DUMP_CHECKSUM_EN
        out_valid = (state == SEND) || (state == SUM);
`else
        out_valid = (state == SEND);
`endif
    end

    // index counter, beat registers, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 5'd0;
            out_data  <= '0;
            out_index <= 5'd0;
            out_last  <= 1'b0;
            done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc       <= '0;
            sum_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    idx <= 5'd0;
`ifdef DUMP_CHECKSUM_EN
                    acc <= '0;
`endif
                end
                FETCH: begin
                    out_data  <= debug_reg_out;
                    out_index <= idx;
`ifdef DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    sum_q     <= 1'b0;
`else
                    out_last  <= idx_last;
`endif
                end
                SEND: begin
                    if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
                        acc <= acc ^ out_data;
`endif
                        if (!idx_last) begin
                            idx <= idx + 5'd1;
                        end else begin
                            // index returns to 0 as the dump leaves the register walk
                            idx <= 5'd0;
`ifdef DUMP_CHECKSUM_EN
                            // x31 is folded in here directly since acc lags by one beat
                            out_data  <= acc ^ out_data;
                            out_index <= 5'd0;
                            out_last  <= 1'b1;
                            sum_q     <= 1'b1;
`else
                            out_last  <= 1'b0;
                            done      <= 1'b1;
`endif
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                SUM: begin
                    if (handshake) begin
                        out_last <= 1'b0;
                        sum_q    <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                default: idx <= 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_streamer.sv
`timescale 1ns/1ps
module tb_reg_dump_streamer;

`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 33;
    localparam bit CK = 1'b1;
`else
    localparam int NB = 32;
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  debug_reg;
    logic [31:0] debug_reg_out;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_sum, out_last, out_valid;
    logic        out_ready = 1'b0;
    logic        busy, done;

    logic [31:0] regs [0:31];
    assign debug_reg_out = regs[debug_reg];

    always #5 clk = ~clk;

    reg_dump_streamer #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .debug_reg(debug_reg), .debug_reg_out(debug_reg_out),
        .out_data(out_data), .out_index(out_index), .out_sum(out_sum),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] got_data  [0:32];
    logic [4:0]  got_index [0:32];
    logic        got_last  [0:32];
    logic        got_sum   [0:32];
    int          n_beats;
    int          hs31_cyc;
    int          unstable;
    logic        fetch_busy, fetch_valid;
    logic [4:0]  fetch_reg;
    logic        dc_done, dc_busy;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one dump from a start pulse and records every accepted beat.
    task automatic run_dump(input int ready_period, input bit hold_start, input bit write_x7);
        bit          pv;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic        pl;
        n_beats = 0; hs31_cyc = -1; unstable = 0; pv = 1'b0;
        pd = '0; pi = '0; pl = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        fetch_busy = busy; fetch_valid = out_valid; fetch_reg = debug_reg;
        for (int cyc = 0; cyc < 3000 && n_beats < NB; cyc++) begin
            out_ready = ((cyc % ready_period) == 0);
            if (hold_start && n_beats >= 10) start = 1'b1;
            if (write_x7 && busy && !out_valid && debug_reg == 5'd3) regs[7] = 32'h12345678;
            if (pv && !(out_valid && out_data == pd && out_index == pi && out_last == pl))
                unstable++;
            pv = out_valid && !out_ready;
            pd = out_data; pi = out_index; pl = out_last;
            if (out_valid && out_ready) begin
                got_data[n_beats]  = out_data;
                got_index[n_beats] = out_index;
                got_last[n_beats]  = out_last;
                got_sum[n_beats]   = out_sum;
                if (n_beats == 31) hs31_cyc = cyc;
                n_beats++;
            end
            tick();
        end
        dc_done = done;
        dc_busy = busy;
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    function automatic logic [31:0] xor_all();
        logic [31:0] x = '0;
        for (int i = 0; i < 32; i++) x ^= regs[i];
        return x;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({busy, out_valid, done, out_sum, out_last} !== 5'b0 || debug_reg !== 5'd0 ||
            out_index !== 5'd0 || out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%0b valid=%0b done=%0b sum=%0b last=%0b reg=%0d idx=%0d data=%h expected all 0",
                     busy, out_valid, done, out_sum, out_last, debug_reg, out_index, out_data);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start: busy=%0b valid=%0b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_full_dump;
        int bad;
        logic [31:0] exp_d;
        run_dump(1, 1'b0, 1'b0);
        vectors++;
        if (fetch_busy !== 1'b1 || fetch_valid !== 1'b0 || fetch_reg !== 5'd0) begin
            miscompares++;
            $display("FAIL first_fetch: busy=%0b valid=%0b reg=%0d expected 1 0 0", fetch_busy, fetch_valid, fetch_reg);
        end
        vectors++;
        if (n_beats != NB) begin
            miscompares++;
            $display("FAIL full_beat_count: got %0d expected %0d", n_beats, NB);
        end
        vectors++;
        if (got_data[2] !== 32'h00007fff || got_data[3] !== 32'h00001000) begin
            miscompares++;
            $display("FAIL full_x2_x3: got %h %h expected 00007fff 00001000", got_data[2], got_data[3]);
        end
        bad = 0;
        for (int i = 0; i < n_beats; i++) begin
            exp_d = (i < 32) ? regs[i] : xor_all();
            if (got_data[i] !== exp_d || got_index[i] !== ((i < 32) ? 5'(i) : 5'd0) ||
                got_last[i] !== (i == NB - 1) || got_sum[i] !== (i == 32)) begin
                bad++;
                $display("FAIL full_beat_%0d: data=%h idx=%0d last=%0b sum=%0b expected data=%h", i,
                         got_data[i], got_index[i], got_last[i], got_sum[i], exp_d);
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
        vectors++;
        if (hs31_cyc + 1 != 64) begin
            miscompares++;
            $display("FAIL full_span: x31 accepted after %0d cycles expected 64", hs31_cyc + 1);
        end
        vectors++;
        if (dc_done !== 1'b1 || dc_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done_cycle: done=%0b busy=%0b expected 1 0", dc_done, dc_busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done_pulse: done=%0b busy=%0b expected 0 0", done, busy);
        end
    endtask

    task automatic test_stall;
        int bad;
        regs[5] = 32'hDEADBEEF;
        run_dump(3, 1'b0, 1'b0);
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL stall_stable: %0d unstable stall cycles expected 0", unstable);
        end
        vectors++;
        if (n_beats != NB || got_data[5] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL stall_x5: beats=%0d data=%h expected %0d deadbeef", n_beats, got_data[5], NB);
        end
        bad = 0;
        for (int i = 0; i < 32 && i < n_beats; i++)
            if (got_index[i] !== 5'(i) || got_data[i] !== regs[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_order: %0d beats out of order or wrong data expected 0", bad);
        end
        vectors++;
        if (dc_done !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done: done=%0b expected 1", dc_done);
        end
    endtask

    task automatic test_start_while_busy;
        int extra;
        run_dump(1, 1'b1, 1'b0);
        vectors++;
        if (n_beats != NB || got_index[NB-1] !== (CK ? 5'd0 : 5'd31)) begin
            miscompares++;
            $display("FAIL busy_start_beats: beats=%0d last_idx=%0d expected %0d", n_beats, got_index[NB-1], NB);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || out_valid !== 1'b0) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL busy_start_single: %0d busy cycles after done expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        run_dump(1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || debug_reg !== 5'd0) begin
            miscompares++;
            $display("FAIL b2b_fetch: busy=%0b valid=%0b reg=%0d expected 1 0 0", busy, out_valid, debug_reg);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 5'd0 || out_data !== regs[0]) begin
            miscompares++;
            $display("FAIL b2b_first_beat: valid=%0b idx=%0d data=%h expected 1 0 %h", out_valid, out_index, out_data, regs[0]);
        end
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset_mid_dump;
        bit reached = 1'b0;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            if (out_valid && out_index == 5'd17) begin
                out_ready = 1'b0;
                reached = 1'b1;
            end
            tick();
        end
        tick();
        vectors++;
        if (!reached || out_valid !== 1'b1 || out_index !== 5'd17 || debug_reg !== 5'd17) begin
            miscompares++;
            $display("FAIL rst_reach17: reached=%0b valid=%0b idx=%0d expected 1 1 17", reached, out_valid, out_index);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || debug_reg !== 5'd0 || out_index !== 5'd0 ||
            out_data !== 32'd0 || out_last !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: valid=%0b busy=%0b reg=%0d idx=%0d data=%h last=%0b done=%0b expected all 0",
                     out_valid, busy, debug_reg, out_index, out_data, out_last, done);
        end
        run_dump(1, 1'b0, 1'b0);
        vectors++;
        if (n_beats != NB || got_index[0] !== 5'd0 || got_index[17] !== 5'd17) begin
            miscompares++;
            $display("FAIL rst_restart: beats=%0d first_idx=%0d expected %0d 0", n_beats, got_index[0], NB);
        end
    endtask

    task automatic test_nonatomic_write;
        regs[7] = 32'd0;
        run_dump(1, 1'b0, 1'b1);
        vectors++;
        if (got_data[7] !== 32'h12345678 || got_data[3] !== 32'h00001000) begin
            miscompares++;
            $display("FAIL nonatomic_x7: x7=%h x3=%h expected 12345678 00001000", got_data[7], got_data[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[2] = 32'h00007fff;
        regs[3] = 32'h00001000;
`ifdef DUMP_CHECKSUM_EN
        regs[1] = 32'h0000000F;
        regs[4] = 32'h000000F0;
`endif
        test_reset();
        test_full_dump();
        test_stall();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_dump();
        test_nonatomic_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
